// File: rtl/hls_deadlock_monitor_if.sv
// Signal bundle between an HLS kernel's stall indications and its deadlock monitor.
// The deadlock_ts member exists only when DEADLOCK_MON_TIMESTAMP_EN is defined.
interface hls_deadlock_monitor_param_if #(
  parameter int NUM_AXIS = 2,
  parameter int NUM_SUB  = 1,
  parameter int THRESH   = 16,
  parameter int CNT_W    = $clog2(THRESH + 1),
  parameter int SRC_W    = $clog2(NUM_AXIS + 1)
);
  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic [NUM_SUB-1:0]  inst_idle_sigs;
  logic [NUM_SUB-1:0]  inst_block_sigs;
  logic                clear;
  logic                block;
  logic                deadlock;
  logic [SRC_W-1:0]    first_src;
  logic [CNT_W-1:0]    stall_cnt;
`ifdef DEADLOCK_MON_TIMESTAMP_EN
  logic [31:0]         deadlock_ts;
`endif

  modport master (
    output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
`ifdef DEADLOCK_MON_TIMESTAMP_EN
    input  deadlock_ts,
`endif
    input  block, deadlock, first_src, stall_cnt
  );

  modport slave (
    input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
`ifdef DEADLOCK_MON_TIMESTAMP_EN
    output deadlock_ts,
`endif
    output block, deadlock, first_src, stall_cnt
  );
endinterface

// File: rtl/hls_deadlock_monitor_param.sv
// Per-kernel deadlock monitor: persistence-filtered sticky deadlock flag with first-source capture.
// Optional entry timestamp enabled by defining DEADLOCK_MON_TIMESTAMP_EN.
//
// state    | meaning
// IDLE     | not blocked last cycle, stall_cnt = 0
// WATCH    | blocked for fewer than THRESH consecutive cycles
// DEADLOCK | THRESH consecutive blocked cycles seen; held until clear
module hls_deadlock_monitor_param #(
  parameter int NUM_AXIS = 2,
  parameter int NUM_SUB  = 1,
  parameter int THRESH   = 16,
  parameter int CNT_W    = $clog2(THRESH + 1),
  parameter int SRC_W    = $clog2(NUM_AXIS + 1)
) (
  input logic clock,
  input logic reset,
  hls_deadlock_monitor_param_if.slave mon
);

  typedef enum logic [1:0] {IDLE, WATCH, DEADLOCK} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SRC_W-1:0] src, lsb_idx;
  logic             blk_q;
  logic             enter;
  logic             axis_blk, sub_blk, seq_blk;

  assign axis_blk = |mon.axis_block_sigs;
  assign sub_blk  = (&(mon.inst_idle_sigs | mon.inst_block_sigs)) & (|mon.inst_block_sigs);
  assign seq_blk  = axis_blk | sub_blk;

  always_comb begin
    lsb_idx = SRC_W'(NUM_AXIS);
    for (int i = NUM_AXIS - 1; i >= 0; i--) begin
      if (mon.axis_block_sigs[i]) lsb_idx = SRC_W'(i);
    end
  end

  // A clear on the completing cycle suppresses the deadlock entry altogether.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    enter     = 1'b0;
    case (state)
      IDLE: begin
        if (!seq_blk) begin
          cnt_nxt = '0;
        end else if (THRESH == 1) begin
          if (mon.clear) begin
            cnt_nxt = '0;
          end else begin
            state_nxt = DEADLOCK;
            cnt_nxt   = CNT_W'(THRESH);
            enter     = 1'b1;
          end
        end else begin
          state_nxt = WATCH;
          cnt_nxt   = CNT_W'(1);
        end
      end
      WATCH: begin
        if (!seq_blk) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(THRESH - 1)) begin
          if (mon.clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = DEADLOCK;
            cnt_nxt   = CNT_W'(THRESH);
            enter     = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DEADLOCK: begin
        if (mon.clear) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      blk_q <= 1'b0;
      src   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      blk_q <= seq_blk;
      if (enter) src <= lsb_idx;
    end
  end

  assign mon.block     = blk_q;
  assign mon.deadlock  = (state == DEADLOCK);
  assign mon.first_src = src;
  assign mon.stall_cnt = cnt;

`ifdef DEADLOCK_MON_TIMESTAMP_EN
  logic [31:0] cycle_cnt, ts;

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt <= '0;
      ts        <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (enter) ts <= cycle_cnt;
    end
  end

  assign mon.deadlock_ts = ts;
`endif

endmodule

// File: doc/hls_deadlock_monitor_param.md
Name: hls_deadlock_monitor_param

Overview:
- Parametrised per-instance deadlock monitor for HLS-generated designs. Successor to the fixed 2-AXIS, 1-instance monitor.
- Generalised to NUM_AXIS AXI-Stream blocking inputs and NUM_SUB sub-instance idle/block pairs.
- Adds a persistence filter: a sticky deadlock flag is set only after THRESH consecutive blocked cycles.
- Captures the first blocking source and provides a clear input. One instance is placed per top-level HLS kernel; its outputs feed the simulation/debug deadlock reporter.

Parameters:
- NUM_AXIS, 2, number of AXIS blocking inputs (>=1).
- NUM_SUB, 1, number of sub-instance idle/block pairs (>=1); tie unused pairs to 0.
- THRESH, 16, consecutive blocked cycles needed to declare deadlock (1..65535).
- CNT_W, $clog2(THRESH+1), width of the stall counter (derived; do not override).
- SRC_W, $clog2(NUM_AXIS+1), width of the source index (derived).

Ports:
- clock  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- axis_block_sigs  input  NUM_AXIS  per-channel AXIS blocked indication.
- inst_idle_sigs  input  NUM_SUB  per-sub-instance idle.
- inst_block_sigs  input  NUM_SUB  per-sub-instance blocked.
- clear  input  1  single-cycle pulse; releases a sticky deadlock.
- block  output  1  registered, unfiltered "blocked this cycle" indication.
- deadlock  output  1  sticky persistent-deadlock flag.
- first_src  output  SRC_W  source captured at deadlock:
  - 0..NUM_AXIS-1 = lowest-index AXIS bit asserted;
  - NUM_AXIS = sub-instance condition only.
- stall_cnt  output  CNT_W  current consecutive-blocked count.

Behaviour:
- Combinational terms:
  - axis_blk = OR(axis_block_sigs).
  - sub_blk = AND(inst_idle_sigs | inst_block_sigs) & OR(inst_block_sigs), i.e. every sub is idle or blocked, and at least one is blocked.
  - seq_blk = axis_blk | sub_blk.
- block: registered copy of seq_blk, 1-cycle latency, no filtering (same timing as the previous generation).
- stall_cnt:
  - If seq_blk, increments by 1 each cycle, saturating at THRESH.
  - If seq_blk is low, returns to 0 on the next edge.
  - Holds its value while in DEADLOCK.
- FSM states: IDLE, WATCH, DEADLOCK.
  - IDLE -> WATCH on an edge with seq_blk=1 and THRESH>1 (stall_cnt becomes 1).
  - IDLE -> DEADLOCK on an edge with seq_blk=1 and THRESH=1.
  - WATCH -> IDLE on an edge with seq_blk=0 (stall_cnt becomes 0).
  - WATCH -> DEADLOCK on an edge with seq_blk=1 and stall_cnt==THRESH-1.
  - DEADLOCK -> IDLE on an edge with clear=1 (stall_cnt becomes 0).
  - DEADLOCK otherwise holds, even if seq_blk deasserts (sticky).
- deadlock = (state==DEADLOCK), registered. It asserts at the edge that completes THRESH consecutive seq_blk cycles.
- first_src:
  - Loaded only on the entry edge into DEADLOCK, from the inputs sampled that cycle.
  - If axis_blk, loads the lowest set bit index; else loads NUM_AXIS.
  - Holds until the next entry into DEADLOCK. It is not cleared by clear.
- Simultaneous events:
  - clear in the same cycle as the deadlock-completing seq_blk: clear wins, the state goes to IDLE, and stall_cnt becomes 0.
  - clear outside DEADLOCK has no effect.
  - A seq_blk glitch of one low cycle restarts the count from 0.
- Reset mid-operation, including while in DEADLOCK:
  - block=0, deadlock=0, stall_cnt=0, first_src=0, state=IDLE, on the next edge.
  - Reset overrides clear and all inputs.

Optional Feature:
- Macro DEADLOCK_MON_TIMESTAMP_EN.
- When defined:
  - Adds a 32-bit free-running cycle counter, reset to 0 and wrapping modulo 2^32.
  - Adds output port deadlock_ts (32 bits), loaded with the counter value on the entry edge into DEADLOCK and held until the next entry.
  - deadlock_ts resets to 0.
- When undefined: no counter and no port; all other behaviour is identical.

Test Plan:
- NUM_AXIS=2, THRESH=4: axis_block_sigs=2'b10 held for 4 cycles -> block=1 one cycle after the first high cycle; deadlock=1 after the 4th edge; first_src=1; stall_cnt=4.
- THRESH=4: axis_block_sigs high 3 cycles, low 1, high 3 -> deadlock stays 0; stall_cnt sequence 1,2,3,0,1,2,3.
- NUM_SUB=3, idle=3'b101, block=3'b010, axis=0 held THRESH cycles -> deadlock=1, first_src=NUM_AXIS. With idle=3'b100, block=3'b010 -> block stays 0.
- After deadlock, drop all inputs for 5 cycles -> deadlock stays 1. Pulse clear -> deadlock=0 and stall_cnt=0 next edge; first_src unchanged.
- clear asserted on the deadlock-completing cycle -> deadlock never asserts; stall_cnt=0. Reset asserted while in DEADLOCK -> all outputs 0 next edge.
- With DEADLOCK_MON_TIMESTAMP_EN: release reset at cycle 0, block from cycle 10, THRESH=4 -> deadlock_ts=13.
